ram_sp_ctrl: RTL
================

Name: ram_sp_ctrl

Overview:
Request/response front end for the single-port, synchronous-read/synchronous-write RAM (ram_sp_sr_sw). Sits directly upstream of the RAM. Converts a valid/ready request stream into correctly sequenced cs/we/oe/addr cycles, owns the write side of the shared bidirectional data bus, and returns read data as a one-cycle response pulse. Inserts a bus turnaround after every read so the controller and the RAM never drive the data bus in the same cycle.

Parameters:
ADDR_W, 8, RAM address width
DATA_W, 8, RAM data width

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept; high only in IDLE
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle pulse, read data valid
rsp_rdata  out  DATA_W  read data, held until next read completes
ram_cs  out  1  RAM chip select
ram_we  out  1  RAM write enable
ram_oe  out  1  RAM output enable
ram_addr  out  ADDR_W  RAM address
ram_data  inout  DATA_W  shared data bus; driven by controller only in WR

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, port reset. All state updates on rising edge of clk.
- Reset values:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0.
  - ram_cs=0, ram_we=0, ram_oe=0, ram_addr=0.
  - ram_data released (Z).
- Handshake:
  - Transfer occurs when req_valid && req_ready at a rising edge.
  - req_addr, req_we and req_wdata are captured into registers on accept.
  - While busy, requests stall with req_ready=0. No request is dropped.
- All ram_* outputs are registered, decoded from the state.
- FSM states: IDLE, WR, RD, RDCAP, TURN.
  - IDLE: cs=we=oe=0, bus Z. On accept, go to WR if req_we=1, otherwise RD.
  - WR (1 cycle): cs=1, we=1, oe=0, ram_addr=latched addr, bus driven with latched wdata. RAM writes at the end of this cycle. Next state IDLE.
  - RD (1 cycle): cs=1, we=0, oe=1. RAM registers mem[addr] at the end of this cycle. Next state RDCAP.
  - RDCAP (1 cycle): cs=1, oe=1, we=0, bus Z; RAM drives the bus. Sample ram_data into rsp_rdata at the end of this cycle. Next state TURN.
  - TURN (1 cycle): cs=we=oe=0, bus Z, rsp_valid=1. Next state IDLE.
- Latency (accept edge = cycle N):
  - Write: WR in N+1, req_ready high again in N+2. Throughput is 1 write per 2 cycles.
  - Read: rsp_valid in N+3, req_ready high in N+4. Throughput is 1 read per 4 cycles.
- Boundary conditions:
  - Addresses 0 and 2^ADDR_W-1 need no special handling; there is no wrap logic.
  - Read immediately after a write to the same address returns the new data, because the RAM write completes before RD.
  - req_valid held high continuously: back-to-back operations are accepted on each IDLE edge.
  - Reset asserted in any state: next edge forces IDLE with reset values. In-flight operation is abandoned, no rsp_valid is issued, bus is released.
  - Bus contention: the controller drives ram_data only when state==WR, and oe=0 in WR.

Optional Feature:
Macro RAM_SP_CTRL_STATS_EN.
- Defined:
  - Adds outputs wr_cnt[15:0] and rd_cnt[15:0].
  - wr_cnt increments on each WR cycle; rd_cnt increments on each rsp_valid.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counters are absent. Core timing is identical either way.

Decomposition:
- Package ram_sp_pkg holds:
  - state enum (IDLE, WR, RD, RDCAP, TURN).
  - default widths RAM_ADDR_W=8 and RAM_DATA_W=8.
  - stats counter width 16.
- No sub-module. The FSM, tristate driver and optional counters stay in one module.
- Bench instantiates ram_sp_ctrl + ram_sp_sr_sw connected on ram_* nets.

Test Plan:
- Reset: hold reset 3 cycles mid-read, then release -> all ram_* = 0, bus Z, req_ready=1, no rsp_valid.
- Single write/read: write addr 8'h10 data 8'hA5, then read 8'h10 -> rsp_valid exactly 3 cycles after read accept, rsp_rdata=8'hA5.
- Boundaries: write 8'h00<-8'h11 and 8'hFF<-8'hEE, then read both -> 8'h11, 8'hEE returned in order.
- Back-to-back with req_valid held high: write 8'h20<-8'h3C, then read 8'h20 -> second accept 2 cycles after first, response 8'h3C. No cycle has the controller driving the bus while ram_oe=1.
- Stall: present read while in RD -> req_ready=0 and request stable until IDLE. Accepted once, exactly one rsp_valid.
- RAM_SP_CTRL_STATS_EN: 5 writes and 3 reads -> wr_cnt=5, rd_cnt=3. Preload 16'hFFFE, do 3 writes -> wr_cnt=16'hFFFF.

Source files
------------

// File: rtl/ram_sp_pkg.sv
// Shared types and defaults for the single-port RAM front end.
package ram_sp_pkg;

  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DATA_W = 8;
  localparam int STATS_W    = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    RDCAP = 3'd3,
    TURN  = 3'd4
  } state_e;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == {STATS_W{1'b1}}) ? v : v + {{(STATS_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/ram_sp_sr_sw.sv
// Behavioural single-port RAM, synchronous read and write, with a shared
// bidirectional data bus that it drives only while selected for reading.
module ram_sp_sr_sw #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              cs,
  input  logic              we,
  input  logic              oe,
  input  logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (cs && we) begin
      mem[addr] <= data;
    end
    if (cs && !we) begin
      dout_q <= mem[addr];
    end
  end

  assign data = (cs && oe && !we) ? dout_q : {DATA_W{1'bz}};

endmodule

// File: rtl/ram_sp_ctrl.sv
// Valid/ready front end for ram_sp_sr_sw: sequences cs/we/oe, owns the write
// side of the data bus, inserts a turnaround after reads. Optional activity
// counters are enabled with RAM_SP_CTRL_STATS_EN.
module ram_sp_ctrl
  import ram_sp_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  output logic               rsp_valid,
  output logic [DATA_W-1:0]  rsp_rdata,
  output logic               ram_cs,
  output logic               ram_we,
  output logic               ram_oe,
  output logic [ADDR_W-1:0]  ram_addr,
`ifdef RAM_SP_CTRL_STATS_EN
  output logic [STATS_W-1:0] wr_cnt,
  output logic [STATS_W-1:0] rd_cnt,
`endif
  inout  wire  [DATA_W-1:0]  ram_data
);

  state_e            state_q;
  state_e            state_d;
  logic [DATA_W-1:0] wdata_q;
  logic              accept;
  logic              bus_drive;

  assign accept    = req_valid && req_ready;
  assign bus_drive = (state_q == WR);
  assign ram_data  = bus_drive ? wdata_q : {DATA_W{1'bz}};

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = req_we ? WR : RD;
        end else begin
          state_d = IDLE;
        end
      end
      WR:      state_d = IDLE;
      RD:      state_d = RDCAP;
      RDCAP:   state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; every RAM-facing output is registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= {DATA_W{1'b0}};
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
      ram_addr  <= {ADDR_W{1'b0}};
      wdata_q   <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      if (accept) begin
        ram_addr <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (state_q == RDCAP) begin
        rsp_rdata <= ram_data;
      end
      case (state_d)
        IDLE: begin
          req_ready <= 1'b1; rsp_valid <= 1'b0;
          ram_cs <= 1'b0; ram_we <= 1'b0; ram_oe <= 1'b0;
        end
        WR: begin
          req_ready <= 1'b0; rsp_valid <= 1'b0;
          ram_cs <= 1'b1; ram_we <= 1'b1; ram_oe <= 1'b0;
        end
        RD, RDCAP: begin
          req_ready <= 1'b0; rsp_valid <= 1'b0;
          ram_cs <= 1'b1; ram_we <= 1'b0; ram_oe <= 1'b1;
        end
        TURN: begin
          req_ready <= 1'b0; rsp_valid <= 1'b1;
          ram_cs <= 1'b0; ram_we <= 1'b0; ram_oe <= 1'b0;
        end
        default: begin
          req_ready <= 1'b1; rsp_valid <= 1'b0;
          ram_cs <= 1'b0; ram_we <= 1'b0; ram_oe <= 1'b0;
        end
      endcase
    end
  end

`ifdef RAM_SP_CTRL_STATS_EN
  logic [STATS_W-1:0] wr_cnt_q;
  logic [STATS_W-1:0] rd_cnt_q;
  logic [STATS_W-1:0] wr_cnt_d;
  logic [STATS_W-1:0] rd_cnt_d;

  assign wr_cnt_d = (state_q == WR) ? sat_inc(wr_cnt_q) : wr_cnt_q;
  assign rd_cnt_d = rsp_valid ? sat_inc(rd_cnt_q) : rd_cnt_q;

  // Saturating activity counters
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt_q <= {STATS_W{1'b0}};
      rd_cnt_q <= {STATS_W{1'b0}};
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign wr_cnt = wr_cnt_q;
  assign rd_cnt = rd_cnt_q;
`endif

endmodule
